// File: rtl/rv32v_types_pkg.sv
// Shared types for the vector-lane datapath.
//   sew_t       : selected element width
//   mul_ctrl_t  : per-element control carried down the multiply pipeline
//   sew_bits()  : element width in bits for a sew_t value
package rv32v_types_pkg;

    typedef enum logic [1:0] {
        SEW8  = 2'd0,
        SEW16 = 2'd1,
        SEW32 = 2'd2
    } sew_t;

    localparam int unsigned MUL_MAX_STAGES = 4;
    // Tag field is sized for the widest lane configuration; narrower tags are
    // zero-extended into it.
    localparam int unsigned MUL_TAG_MAX_W  = 16;

    typedef struct packed {
        logic [1:0]               is_signed;  // bit0 vs1, bit1 vs2
        logic                     high_low;
        logic                     widen;
        logic                     macc;
        logic                     negate;
        sew_t                     sew;
        logic [MUL_TAG_MAX_W-1:0] tag;
    } mul_ctrl_t;

    function automatic int unsigned sew_bits(sew_t s);
        case (s)
            SEW8:    return 8;
            SEW16:   return 16;
            default: return 32;
        endcase
    endfunction

endpackage

// File: rtl/vmul_pipe_reg.sv
// Generic valid/payload pipeline stage.
//   CLK, nRST  : clock, asynchronous active-low reset
//   i_load     : capture i_data and become valid
//   i_advance  : current content moves on this cycle
//   i_flush    : drop content at the next edge (wins over i_load)
//   i_data     : incoming payload
//   o_valid    : stage holds an element
//   o_data     : registered payload
module vmul_pipe_reg #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             CLK,
    input  logic             nRST,
    input  logic             i_load,
    input  logic             i_advance,
    input  logic             i_flush,
    input  logic [WIDTH-1:0] i_data,
    output logic             o_valid,
    output logic [WIDTH-1:0] o_data
);

    logic             r_valid;
    logic [WIDTH-1:0] r_data;

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_valid <= 1'b0;
        end else if (i_flush) begin
            r_valid <= 1'b0;
        end else if (i_load) begin
            r_valid <= 1'b1;
        end else if (i_advance) begin
            r_valid <= 1'b0;
        end
    end

    // Payload is reset so the unit drives zeros before its first result.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_data <= '0;
        end else if (i_load) begin
            r_data <= i_data;
        end
    end

    assign o_valid = r_valid;
    assign o_data  = r_data;

endmodule

// File: rtl/vector_mul_pipe.sv
// Pipelined vector-lane integer multiply / multiply-accumulate unit.
//   CLK, nRST                    : clock, asynchronous active-low reset
//   in_valid/in_ready            : operand handshake
//   vs1/vs2/vs3_data             : multiplier, multiplicand, accumulator
//   sew, is_signed, high_low,
//   widen, macc, negate, tag_in  : per-element control and tag
//   flush                        : discard every in-flight element
//   out_valid/out_ready          : result handshake
//   out_data, out_tag            : result and its tag
//   busy                         : any stage holds an element
// STAGES must lie in 1..MUL_MAX_STAGES.
module vector_mul_pipe
    import rv32v_types_pkg::*;
#(
    parameter int unsigned XLEN   = 32,
    parameter int unsigned STAGES = 3,
    parameter int unsigned TAG_W  = 5
) (
    input  logic             CLK,
    input  logic             nRST,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [XLEN-1:0]  vs1_data,
    input  logic [XLEN-1:0]  vs2_data,
    input  logic [XLEN-1:0]  vs3_data,
    input  sew_t             sew,
    input  logic [1:0]       is_signed,
    input  logic             high_low,
    input  logic             widen,
    input  logic             macc,
    input  logic             negate,
    input  logic [TAG_W-1:0] tag_in,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  out_data,
    output logic [TAG_W-1:0] out_tag,
    output logic             busy
);

    typedef struct packed {
        mul_ctrl_t          ctrl;
        logic [XLEN-1:0]    op1;
        logic [XLEN-1:0]    op2;
        logic [XLEN-1:0]    acc;
        logic [2*XLEN-1:0]  prod;
    } payload_t;

    // Truncate to SEW, then sign- or zero-extend back to XLEN.
    function automatic logic [XLEN-1:0] ext_op(logic [XLEN-1:0] v, sew_t s, logic sg);
        int unsigned             sh;
        logic [XLEN-1:0]         t;
        logic signed [XLEN-1:0]  ts;
        sh = XLEN - sew_bits(s);
        t  = v << sh;
        if (sg) begin
            ts = $signed(t) >>> sh;
            return $unsigned(ts);
        end
        return t >> sh;
    endfunction

    // Full product via a signed multiply on one-bit-widened operands, so the
    // four signed/unsigned combinations share one multiplier.
    function automatic logic [2*XLEN-1:0] mul_full(logic [XLEN-1:0] a, logic [XLEN-1:0] b,
                                                   logic [1:0] sg);
        logic signed [XLEN:0]     a_s;
        logic signed [XLEN:0]     b_s;
        logic signed [2*XLEN+1:0] p;
        a_s = {sg[0] & a[XLEN-1], a};
        b_s = {sg[1] & b[XLEN-1], b};
        p   = a_s * b_s;
        return p[2*XLEN-1:0];
    endfunction

    function automatic logic [XLEN-1:0] low_mask(int unsigned n);
        logic [XLEN-1:0] one;
        one = 1;
        if (n >= XLEN) return '1;
        return (one << n) - one;
    endfunction

    logic [STAGES-1:0] w_valid;
    logic [STAGES-1:0] w_adv;
    logic [STAGES-1:0] w_load;
    logic [STAGES:0]   w_room;
    payload_t          w_data [STAGES];
    payload_t          w_in_payload;
    payload_t          w_last;
    logic [2*XLEN-1:0] w_prod;

    // Stage k can take a new element when empty or when its content moves on
    // this cycle; computed from the output end so bubbles collapse.
    always_comb begin
        w_room         = '0;
        w_adv          = '0;
        w_room[STAGES] = out_ready;
        for (int k = STAGES - 1; k >= 0; k--) begin
            w_adv[k]  = w_valid[k] & w_room[k+1];
            w_room[k] = !w_valid[k] | w_adv[k];
        end
    end

    assign in_ready = w_room[0] & !flush;

    always_comb begin
        w_load    = '0;
        w_load[0] = in_valid & in_ready;
        for (int k = 1; k < STAGES; k++) begin
            w_load[k] = w_adv[k-1];
        end
    end

    always_comb begin
        w_in_payload                     = '0;
        w_in_payload.ctrl.is_signed      = is_signed;
        w_in_payload.ctrl.high_low       = high_low;
        w_in_payload.ctrl.widen          = widen;
        w_in_payload.ctrl.macc           = macc;
        w_in_payload.ctrl.negate         = negate;
        w_in_payload.ctrl.sew            = sew;
        w_in_payload.ctrl.tag[TAG_W-1:0] = tag_in;
        w_in_payload.op1                 = ext_op(vs1_data, sew, is_signed[0]);
        w_in_payload.op2                 = ext_op(vs2_data, sew, is_signed[1]);
        w_in_payload.acc                 = vs3_data;
    end

    for (genvar g = 0; g < STAGES; g++) begin : g_stage
        payload_t w_din;
        if (g == 0) begin : g_first
            assign w_din = w_in_payload;
        end else if (g == 1) begin : g_mul
            // Product is formed between stage 1 and stage 2.
            always_comb begin
                w_din      = w_data[0];
                w_din.prod = mul_full(w_data[0].op1, w_data[0].op2, w_data[0].ctrl.is_signed);
            end
        end else begin : g_pass
            assign w_din = w_data[g-1];
        end

        vmul_pipe_reg #(
            .WIDTH ($bits(payload_t))
        ) u_reg (
            .CLK       (CLK),
            .nRST      (nRST),
            .i_load    (w_load[g]),
            .i_advance (w_adv[g]),
            .i_flush   (flush),
            .i_data    (w_din),
            .o_valid   (w_valid[g]),
            .o_data    (w_data[g])
        );
    end

    assign w_last = w_data[STAGES-1];

    if (STAGES == 1) begin : g_prod_comb
        assign w_prod = mul_full(w_last.op1, w_last.op2, w_last.ctrl.is_signed);
    end else begin : g_prod_reg
        assign w_prod = w_last.prod;
    end

    int unsigned       w_sew_bits;
    int unsigned       w_res_bits;
    logic [XLEN-1:0]   w_sel;
    logic [XLEN-1:0]   w_res;
    logic [2*XLEN-1:0] w_sel_full;

    always_comb begin
        w_sew_bits = sew_bits(w_last.ctrl.sew);
        w_res_bits = w_last.ctrl.widen ? 2 * w_sew_bits : w_sew_bits;
        w_sel_full = w_prod;
        if (!w_last.ctrl.widen && w_last.ctrl.high_low) begin
            w_sel_full = w_prod >> w_sew_bits;
        end
        w_sel = w_sel_full[XLEN-1:0] & low_mask(w_res_bits);
        w_res = w_sel;
        if (w_last.ctrl.macc) begin
            w_res = w_last.ctrl.negate ? (w_last.acc - w_sel) : (w_last.acc + w_sel);
        end
    end

    assign out_data  = w_res & low_mask(w_res_bits);
    assign out_tag   = w_last.ctrl.tag[TAG_W-1:0];
    assign out_valid = w_valid[STAGES-1];
    assign busy      = |w_valid;

    // Fields not consumed at their pipeline position.
    logic w_unused_payload;
    assign w_unused_payload = ^{w_data[0].prod, w_last.op1, w_last.op2, w_last.ctrl.tag};

endmodule

// File: doc/vector_mul_pipe.md
# vector_mul_pipe

Pipelined, parametrised vector-lane integer multiply unit with valid/ready handshakes. It accepts one element per cycle and supports SEW 8/16/32, signed/unsigned/mixed operands, high/low and widening selects, and multiply-accumulate with optional negation (vmacc/vnmsac family). Results return in order after STAGES cycles, carrying a tag. The block sits in each vector lane between the lane issue logic and the lane writeback arbiter, replacing the single-element start/done multiply unit.

## Interface
Parameters:
- XLEN, 32: lane element datapath width.
- STAGES, 3: pipeline register stages, legal range 1..4.
- TAG_W, 5: width of the per-element tag (element index/destination id).

Ports:
- CLK  in  1  clock
- nRST  in  1  reset, asynchronous, active-low
- in_valid  in  1  operands valid
- in_ready  out  1  unit can accept this cycle
- vs1_data, vs2_data, vs3_data  in  XLEN  multiplier, multiplicand, accumulator
- sew  in  2  sew_t: SEW8, SEW16, SEW32
- is_signed  in  2  bit0 = vs1 signed, bit1 = vs2 signed
- high_low  in  1  1 = upper SEW half of product
- widen  in  1  return 2·SEW-bit product
- macc  in  1  add product to vs3
- negate  in  1  with macc: vs3 − product
- tag_in  in  TAG_W  tag accompanying the element
- flush  in  1  synchronous discard of all in-flight elements
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts result
- out_data  out  XLEN  result
- out_tag  out  TAG_W  tag of the result
- busy  out  1  any stage holds a valid element

## Operation
- Accept when in_valid & in_ready. Output transfer occurs when out_valid & out_ready.
- Operand extension: each operand is truncated to SEW bits, then sign-extended if its is_signed bit is set, else zero-extended, to XLEN. The full 2·XLEN product uses the signed/unsigned combination given by is_signed.
- Select, with W = widen ? 2·SEW : SEW:
  - widen = 1: product[2·SEW−1:0].
  - high_low = 1: product[2·SEW−1:SEW].
  - otherwise: product[SEW−1:0].
  - widen overrides high_low. widen with SEW32 returns product[31:0].
- Accumulate: if macc, r = vs3 + sel, or r = vs3 − sel when negate; else r = sel. r is truncated to W bits and zero-extended to XLEN.
- negate without macc is ignored.
- Pipeline placement:
  - Stage 1 registers the extended operands plus control and tag.
  - Multiply completes by the last stage.
  - Select and accumulate are combinational on the last stage's register.
- Stall: each stage advances when the next stage is empty or advancing. The last stage advances when out_ready is high. Bubbles collapse.
- in_ready = !stage1_valid | stage1_advances.
- flush clears every valid bit at the next edge and forces in_ready low in that cycle. No element is accepted while flush is asserted.
- Reset mid-operation: all valids are cleared immediately and in-flight elements are discarded.

## Timing
- Reset values: in_ready 1, out_valid 0, out_data 0, out_tag 0, busy 0.
- Latency: accepted at edge N, out_valid is high after edge N+STAGES−1, i.e. STAGES cycles including the accept cycle when unstalled.
- Throughput: 1 element/cycle with out_ready held high.
- While out_valid & !out_ready, out_data and out_tag are stable. A full pipeline holds STAGES elements, after which in_ready drops.
- Simultaneous out transfer and input accept on a full pipeline: accepted with no bubble.
- flush together with an output transfer: the transfer completes and the pipeline is empty on the next cycle.

## Structure
- rv32v_types_pkg holds:
  - sew_t (SEW8/16/32).
  - mul_ctrl_t: packed struct of is_signed, high_low, widen, macc, negate, sew, tag.
  - MUL_MAX_STAGES = 4.
- Sub-module vmul_pipe_reg is a generic valid/payload stage with advance/flush, instantiated STAGES times via generate.
- The product is computed with a behavioural 2·XLEN signed multiply on 33-bit sign-adjusted operands. No iterative multiplier is used.

## Test plan
- SEW32 unsigned low, vs1=0xFFFF_FFFF, vs2=2 → out_data 0xFFFF_FFFE after STAGES cycles. High select gives 0x0000_0001.
- SEW8 signed×signed high, vs1=0x80, vs2=0x80 (−128·−128) → high 0x40, low 0x00. Mixed su (vs2 signed 0xFF, vs1 unsigned 0xFF) high → 0xFF.
- SEW16 widen, vs1=0xFFFF, vs2=0xFFFF unsigned → 0xFFFE_0001. Signed → 0x0000_0001.
- macc SEW32 vs3=10, vs1=3, vs2=4 → 22. With negate → 0xFFFF_FFFE. SEW8 macc vs3=0xFF, product 1 → 0x00, with upper bits zero.
- Back-pressure: stream 8 elements with tags 0..7 and out_ready low for 5 cycles. in_ready drops after STAGES accepts; all 8 results return in order with no loss or duplication.
- Flush with 3 in flight → next cycle busy=0 and out_valid=0. The next element after flush returns with the correct tag.
